// File: rtl/seg7_mux_ctrl_if.sv
// seg7_mux_ctrl_if: load/convert handshake and multiplexed display pins of seg7_mux_ctrl
interface seg7_mux_ctrl_if #(parameter int DIGITS = 4, parameter int BIN_W = 14);
  logic [BIN_W-1:0] bin_in;
  logic load;
  logic busy;
  logic ovf;
  logic [DIGITS-1:0] anode;
  logic [6:0] cathode;
  modport master (output bin_in, load, input busy, ovf, anode, cathode);
  modport slave (input bin_in, load, output busy, ovf, anode, cathode);
endinterface

// File: rtl/seg7_mux_ctrl.sv
// seg7_mux_ctrl: sequential double-dabble binary-to-BCD with multiplexed 7-segment scan; SEG7_LZ_BLANK_EN blanks leading zeros
module seg7_mux_ctrl #(
  parameter int DIGITS = 4,
  parameter int BIN_W = 14,
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst,
  seg7_mux_ctrl_if.slave bus
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    OFF, OFF, OFF, OFF, OFF, OFF};
  logic [BIN_W-1:0] sh;
  logic [DW-1:0] bcd, adj, disp, bcd_n;
  logic [CW-1:0] cnt;
  logic of, of_n, busy, ovf, wrap;
  logic [RW-1:0] rc;
  logic [IW-1:0] idx;
  logic [DIGITS-1:0] blank, anode;
  logic [3:0] dig;
  logic [6:0] cathode, seg_n;
`ifdef SEG7_LZ_BLANK_EN
  logic zc;
`endif
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    bcd_n = {adj[DW-2:0], sh[BIN_W-1]};
    of_n = of | adj[DW-1];
    blank = '0;
`ifdef SEG7_LZ_BLANK_EN
    zc = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zc = zc & (disp[4*i +: 4] == 4'd0);
      blank[i] = zc;
    end
`endif
    dig = 4'(disp >> {idx, 2'b00});
    seg_n = ovf ? DASH : blank[idx] ? OFF : SEG[dig];
    wrap = rc == RW'(REFRESH_DIV - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      ovf <= 1'b0;
      disp <= '0;
      rc <= '0;
      idx <= '0;
      anode <= '1;
      cathode <= OFF;
      sh <= '0;
      bcd <= '0;
      of <= 1'b0;
      cnt <= '0;
    end else begin
      anode <= ~(DIGITS'(1) << idx);
      cathode <= seg_n;
      rc <= wrap ? '0 : rc + 1'b1;
      if (wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      if (busy) begin
        sh <= sh << 1;
        bcd <= bcd_n;
        of <= of_n;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(BIN_W - 1)) begin
          busy <= 1'b0;
          disp <= bcd_n;
          ovf <= of_n;
        end
      end else if (bus.load) begin
        sh <= bus.bin_in;
        bcd <= '0;
        of <= 1'b0;
        cnt <= '0;
        busy <= 1'b1;
      end
    end
  end
  assign bus.busy = busy;
  assign bus.ovf = ovf;
  assign bus.anode = anode;
  assign bus.cathode = cathode;
endmodule

// File: doc/seg7_mux_ctrl.md
SEG7_MUX_CTRL -- requirements
Module: seg7_mux_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of displayed decimal digits (1..8).
REQ-002 Parameter BIN_W, default 14, width of binary input (1..27).
REQ-003 Parameter REFRESH_DIV, default 100000, clk cycles each digit is lit (>=2).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 bin_in  input  BIN_W  unsigned binary value to display.
REQ-007 load  input  1  single-cycle request to convert and display bin_in.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 ovf  output  1  high when the displayed value exceeded 10^DIGITS-1.
REQ-010 anode  output  DIGITS  active-low digit enables; bit 0 = units.
REQ-011 cathode  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-012 Conversion SHALL be sequential shift-add-3 (double dabble), one input bit per cycle, no division or modulo operators.
REQ-013 load sampled while busy=0 SHALL capture bin_in and set busy=1 on the next cycle.
REQ-014 busy SHALL stay high exactly BIN_W cycles, then fall; the displayed digit register and ovf SHALL update on the same edge that busy falls.
REQ-015 load while busy=1 SHALL be ignored; the in-flight conversion SHALL complete unaffected.
REQ-016 Display register SHALL hold the last completed result until the next completion.
REQ-017 If the captured value > 10^DIGITS-1, ovf SHALL be 1 and every digit SHALL show dash (cathode 0111111); otherwise ovf=0.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance by 1, wrapping DIGITS-1 -> 0.
REQ-019 Exactly one anode bit (the current index) SHALL be low at any time after reset; anode and cathode SHALL change on the same edge.
REQ-020 Segment codes 0-9 SHALL be: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-021 The refresh scan SHALL run independently of conversion; a completion mid-scan SHALL take effect on the currently lit digit on the next cycle.

Reset
REQ-022 On rst: anode all 1, cathode 1111111, busy 0, ovf 0, display register all zero digits, digit index 0, refresh counter 0.
REQ-023 rst during a conversion SHALL abort it; the aborted value SHALL never reach the display.
REQ-024 First cycle after rst release SHALL light digit 0 showing 0 (cathode 1000000).

Configuration
REQ-025 Macro SEG7_LZ_BLANK_EN: when defined, leading zero digits above the most-significant nonzero digit SHALL be blanked (anode still scanned, cathode 1111111); digit 0 SHALL never blank.
REQ-026 Without SEG7_LZ_BLANK_EN, all digits SHALL show their value including leading zeros.
REQ-027 Macro SHALL NOT affect busy timing, ovf, or overflow dash display.

Verification
REQ-028 Defaults, REFRESH_DIV=4; rst, load bin_in=1234 -> busy high 14 cycles, then digits 0..3 show 4,3,2,1; each anode low 4 cycles, rotation 1110,1101,1011,0111.
REQ-029 load bin_in=10000 (DIGITS=4) -> ovf=1, all four digits show 0111111; then load 9999 -> ovf=0, all show 0010000.
REQ-030 load 5678, pulse load with 42 at cycle 3 of busy -> ignored; display 5678 after 14 cycles.
REQ-031 load 777, assert rst at busy cycle 7 -> display returns to 0000, busy 0, 777 never appears.
REQ-032 load 7 with SEG7_LZ_BLANK_EN -> digits 3..1 cathode 1111111, digit 0 1111000; without macro -> digits 3..1 show 1000000.
REQ-033 DIGITS=6, BIN_W=20, load 999999 -> six digits show 9, ovf=0, busy exactly 20 cycles.
